// File: rtl/bgr_pkg.sv
// Shared types and width helpers for the background-removal PE array.
// The tile datapath is sized by module parameters, so rgb_t is declared per module.
package bgr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SUM,
        ST_SUM_DONE,
        ST_RMV,
        ST_RMV_DONE
    } bgr_state_t;

    // Sum of three absolute channel differences needs two extra bits.
    function automatic int bgr_dist_w(input int pix_w);
        return pix_w + 2;
    endfunction

    function automatic int bgr_sum_w(input int pix_w, input int num_pix);
        return pix_w + $clog2(num_pix);
    endfunction

endpackage

// File: rtl/bgr_pixel_classify.sv
// Combinational L1 colour distance, threshold compare and background substitution.
// One instance is shared across all pixels of the tile.
module bgr_pixel_classify
    import bgr_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int DIST_W = bgr_dist_w(PIX_W)
) (
    input  logic [PIX_W-1:0]  i_red,
    input  logic [PIX_W-1:0]  i_green,
    input  logic [PIX_W-1:0]  i_blue,
    input  logic [PIX_W-1:0]  i_exp_red,
    input  logic [PIX_W-1:0]  i_exp_green,
    input  logic [PIX_W-1:0]  i_exp_blue,
    input  logic [PIX_W-1:0]  i_bg_red,
    input  logic [PIX_W-1:0]  i_bg_green,
    input  logic [PIX_W-1:0]  i_bg_blue,
    input  logic [DIST_W-1:0] i_threshold,
    output logic [PIX_W-1:0]  o_red,
    output logic [PIX_W-1:0]  o_green,
    output logic [PIX_W-1:0]  o_blue,
    output logic              o_match
);

    logic [PIX_W-1:0]  w_dr;
    logic [PIX_W-1:0]  w_dg;
    logic [PIX_W-1:0]  w_db;
    logic [DIST_W-1:0] w_dist;

    assign w_dr = (i_red   >= i_exp_red)   ? (i_red   - i_exp_red)   : (i_exp_red   - i_red);
    assign w_dg = (i_green >= i_exp_green) ? (i_green - i_exp_green) : (i_exp_green - i_green);
    assign w_db = (i_blue  >= i_exp_blue)  ? (i_blue  - i_exp_blue)  : (i_exp_blue  - i_blue);

    assign w_dist  = DIST_W'(w_dr) + DIST_W'(w_dg) + DIST_W'(w_db);
    assign o_match = (w_dist <= i_threshold);

    assign o_red   = o_match ? i_bg_red   : i_red;
    assign o_green = o_match ? i_bg_green : i_green;
    assign o_blue  = o_match ? i_bg_blue  : i_blue;

endmodule

// File: rtl/bg_removal_pe_array.sv
// Tile-based background removal: buffers NUM_PIX pixels, optionally sums them,
// then streams classified/replaced pixels out under valid/ready flow control.
module bg_removal_pe_array
    import bgr_pkg::*;
#(
    parameter int PIX_W   = 8,
    parameter int NUM_PIX = 4,
    localparam int IDX_W  = $clog2(NUM_PIX),
    localparam int SUM_W  = bgr_sum_w(PIX_W, NUM_PIX),
    localparam int DIST_W = bgr_dist_w(PIX_W)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [PIX_W-1:0]  Red_In,
    input  logic [PIX_W-1:0]  Green_In,
    input  logic [PIX_W-1:0]  Blue_In,
    input  logic              Start_Sum,
    input  logic              Start_BgRemoval,
    input  logic              Ack,
    input  logic              Use_Avg,
    input  logic [PIX_W-1:0]  Red_Exp,
    input  logic [PIX_W-1:0]  Green_Exp,
    input  logic [PIX_W-1:0]  Blue_Exp,
    input  logic [DIST_W-1:0] Threshold,
    input  logic [PIX_W-1:0]  Bg_Red,
    input  logic [PIX_W-1:0]  Bg_Green,
    input  logic [PIX_W-1:0]  Bg_Blue,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [PIX_W-1:0]  Red_Out,
    output logic [PIX_W-1:0]  Green_Out,
    output logic [PIX_W-1:0]  Blue_Out,
    output logic [SUM_W-1:0]  Red_Sum,
    output logic [SUM_W-1:0]  Green_Sum,
    output logic [SUM_W-1:0]  Blue_Sum,
    output logic              Sum_Valid,
    output logic              Buffer_Full,
    output logic [IDX_W:0]    Replaced_Count,
    output logic              Busy,
    output logic              Done
);

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_t;

    localparam logic [IDX_W:0] CNT_FULL = (IDX_W + 1)'(NUM_PIX);
    localparam logic [IDX_W:0] IDX_LAST = (IDX_W + 1)'(NUM_PIX - 1);

    bgr_state_t        r_state;
    bgr_state_t        w_state_next;
    logic [IDX_W:0]    r_count;
    logic [IDX_W:0]    r_idx;
    rgb_t              r_buf [NUM_PIX];
    logic [SUM_W-1:0]  r_sum_r;
    logic [SUM_W-1:0]  r_sum_g;
    logic [SUM_W-1:0]  r_sum_b;
    logic              r_sum_valid;
    rgb_t              r_exp;
    rgb_t              r_out;
    logic              r_out_valid;
    logic [IDX_W:0]    r_replaced;

    logic              w_idle;
    logic              w_full;
    logic              w_in_ready;
    logic              w_load;
    logic              w_start_sum;
    logic              w_start_rmv;
    logic              w_last_sum;
    logic              w_out_load;
    logic              w_out_fire;
    logic              w_rmv_end;
    rgb_t              w_rd_pix;
    rgb_t              w_cls_pix;
    logic              w_cls_match;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_full      = (r_count == CNT_FULL);
    assign w_in_ready  = w_idle && !w_full;
    assign w_load      = In_Valid && w_in_ready;
    // Start_Sum takes priority when both pulses arrive together.
    assign w_start_sum = Start_Sum && w_idle && w_full;
    assign w_start_rmv = Start_BgRemoval && !Start_Sum && w_idle && w_full;
    assign w_last_sum  = (r_state == ST_SUM) && (r_idx == IDX_LAST);
    assign w_out_fire  = r_out_valid && Out_Ready;
    assign w_out_load  = (r_state == ST_RMV) && (!r_out_valid || Out_Ready) && (r_idx < CNT_FULL);
    assign w_rmv_end   = (r_state == ST_RMV) && w_out_fire && (r_idx == CNT_FULL);
    assign w_rd_pix    = r_buf[r_idx[IDX_W-1:0]];

    // Tile buffer: one write-enabled register per slot, addressed by the fill count.
    for (genvar gi = 0; gi < NUM_PIX; gi++) begin : g_buf
        always_ff @(posedge Clk) begin
            if (w_load && (r_count[IDX_W-1:0] == IDX_W'(gi))) begin
                r_buf[gi] <= '{r: Red_In, g: Green_In, b: Blue_In};
            end
        end
    end

    bgr_pixel_classify #(
        .PIX_W  (PIX_W),
        .DIST_W (DIST_W)
    ) u_classify (
        .i_red       (w_rd_pix.r),
        .i_green     (w_rd_pix.g),
        .i_blue      (w_rd_pix.b),
        .i_exp_red   (r_exp.r),
        .i_exp_green (r_exp.g),
        .i_exp_blue  (r_exp.b),
        .i_bg_red    (Bg_Red),
        .i_bg_green  (Bg_Green),
        .i_bg_blue   (Bg_Blue),
        .i_threshold (Threshold),
        .o_red       (w_cls_pix.r),
        .o_green     (w_cls_pix.g),
        .o_blue      (w_cls_pix.b),
        .o_match     (w_cls_match)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_sum) begin
                    w_state_next = ST_SUM;
                end else if (w_start_rmv) begin
                    w_state_next = ST_RMV;
                end
            end
            ST_SUM:      if (w_last_sum) w_state_next = ST_SUM_DONE;
            ST_SUM_DONE: if (Ack)        w_state_next = ST_IDLE;
            ST_RMV:      if (w_rmv_end)  w_state_next = ST_RMV_DONE;
            ST_RMV_DONE: if (Ack)        w_state_next = ST_IDLE;
            default:                     w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_count     <= '0;
            r_idx       <= '0;
            r_sum_r     <= '0;
            r_sum_g     <= '0;
            r_sum_b     <= '0;
            r_sum_valid <= 1'b0;
            r_exp       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_replaced  <= '0;
        end else begin
            if (w_load) begin
                r_count     <= r_count + 1'b1;
                r_sum_valid <= 1'b0;
            end

            if (w_start_sum) begin
                r_sum_r <= '0;
                r_sum_g <= '0;
                r_sum_b <= '0;
                r_idx   <= '0;
            end

            if (r_state == ST_SUM) begin
                r_sum_r <= r_sum_r + SUM_W'(w_rd_pix.r);
                r_sum_g <= r_sum_g + SUM_W'(w_rd_pix.g);
                r_sum_b <= r_sum_b + SUM_W'(w_rd_pix.b);
                r_idx   <= r_idx + 1'b1;
                if (w_last_sum) begin
                    r_sum_valid <= 1'b1;
                end
            end

            if (w_start_rmv) begin
                r_idx      <= '0;
                r_replaced <= '0;
                // Tile average is a right shift since NUM_PIX is a power of two.
                if (Use_Avg && r_sum_valid) begin
                    r_exp <= '{r: PIX_W'(r_sum_r >> IDX_W),
                               g: PIX_W'(r_sum_g >> IDX_W),
                               b: PIX_W'(r_sum_b >> IDX_W)};
                end else begin
                    r_exp <= '{r: Red_Exp, g: Green_Exp, b: Blue_Exp};
                end
            end

            if (w_out_load) begin
                r_out       <= w_cls_pix;
                r_out_valid <= 1'b1;
                r_idx       <= r_idx + 1'b1;
                if (w_cls_match) begin
                    r_replaced <= r_replaced + 1'b1;
                end
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end

            if ((r_state == ST_RMV_DONE) && Ack) begin
                r_count     <= '0;
                r_sum_valid <= 1'b0;
            end
        end
    end

    assign In_Ready       = w_in_ready;
    assign Out_Valid      = r_out_valid;
    assign Red_Out        = r_out.r;
    assign Green_Out      = r_out.g;
    assign Blue_Out       = r_out.b;
    assign Red_Sum        = r_sum_r;
    assign Green_Sum      = r_sum_g;
    assign Blue_Sum       = r_sum_b;
    assign Sum_Valid      = r_sum_valid;
    assign Buffer_Full    = w_full;
    assign Replaced_Count = r_replaced;
    assign Busy           = (r_state == ST_SUM) || (r_state == ST_RMV);
    assign Done           = (r_state == ST_SUM_DONE) || (r_state == ST_RMV_DONE);

endmodule

// File: tb/tb_bg_removal_pe_array.sv
// Scoreboard bench for bg_removal_pe_array: a reference model predicts sums and
// output pixels; a negedge monitor pops and compares each output handshake.
module tb_bg_removal_pe_array;

    localparam int PIX_W   = 8;
    localparam int NUM_PIX = 4;
    localparam int IDX_W   = 2;
    localparam int SUM_W   = 10;
    localparam int DIST_W  = 10;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              In_Valid = 1'b0;
    logic              In_Ready;
    logic [PIX_W-1:0]  Red_In = '0, Green_In = '0, Blue_In = '0;
    logic              Start_Sum = 1'b0, Start_BgRemoval = 1'b0, Ack = 1'b0, Use_Avg = 1'b0;
    logic [PIX_W-1:0]  Red_Exp = '0, Green_Exp = '0, Blue_Exp = '0;
    logic [DIST_W-1:0] Threshold = '0;
    logic [PIX_W-1:0]  Bg_Red = '0, Bg_Green = '0, Bg_Blue = '0;
    logic              Out_Valid;
    logic              Out_Ready = 1'b0;
    logic [PIX_W-1:0]  Red_Out, Green_Out, Blue_Out;
    logic [SUM_W-1:0]  Red_Sum, Green_Sum, Blue_Sum;
    logic              Sum_Valid, Buffer_Full, Busy, Done;
    logic [IDX_W:0]    Replaced_Count;

    always #5 Clk = ~Clk;

    bg_removal_pe_array #(
        .PIX_W   (PIX_W),
        .NUM_PIX (NUM_PIX)
    ) dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .In_Valid        (In_Valid),
        .In_Ready        (In_Ready),
        .Red_In          (Red_In),
        .Green_In        (Green_In),
        .Blue_In         (Blue_In),
        .Start_Sum       (Start_Sum),
        .Start_BgRemoval (Start_BgRemoval),
        .Ack             (Ack),
        .Use_Avg         (Use_Avg),
        .Red_Exp         (Red_Exp),
        .Green_Exp       (Green_Exp),
        .Blue_Exp        (Blue_Exp),
        .Threshold       (Threshold),
        .Bg_Red          (Bg_Red),
        .Bg_Green        (Bg_Green),
        .Bg_Blue         (Bg_Blue),
        .Out_Valid       (Out_Valid),
        .Out_Ready       (Out_Ready),
        .Red_Out         (Red_Out),
        .Green_Out       (Green_Out),
        .Blue_Out        (Blue_Out),
        .Red_Sum         (Red_Sum),
        .Green_Sum       (Green_Sum),
        .Blue_Sum        (Blue_Sum),
        .Sum_Valid       (Sum_Valid),
        .Buffer_Full     (Buffer_Full),
        .Replaced_Count  (Replaced_Count),
        .Busy            (Busy),
        .Done            (Done)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          m_r [NUM_PIX];
    int          m_g [NUM_PIX];
    int          m_b [NUM_PIX];
    int          m_cnt = 0;
    bit          m_sum_valid = 0;
    int          m_sr = 0, m_sg = 0, m_sb = 0;
    int          exp_replaced = 0;
    logic [23:0] sb_q [$];
    int          hs_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Output monitor: one line per handshake, stall stability enforced.
    initial begin
        logic [23:0] held;
        logic [23:0] e;
        bit          stalled;
        held = '0;
        stalled = 0;
        forever begin
            @(negedge Clk);
            if (!Reset_n) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    check("stall_valid", 32'(Out_Valid), 32'd1);
                    check("stall_data", 32'({Red_Out, Green_Out, Blue_Out}), 32'(held));
                end
                stalled = 0;
                if (Out_Valid && Out_Ready) begin
                    hs_cnt++;
                    $display("out #%0d: (%0d,%0d,%0d)", hs_cnt, Red_Out, Green_Out, Blue_Out);
                    if (sb_q.size() == 0) begin
                        check("out_unexpected", 32'(Out_Valid), 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("out_pix", 32'({Red_Out, Green_Out, Blue_Out}), 32'(e));
                    end
                end else if (Out_Valid) begin
                    stalled = 1;
                    held = {Red_Out, Green_Out, Blue_Out};
                end
            end
        end
    end

    task automatic load_pixel(input int r, input int g, input int b);
        Red_In = PIX_W'(r);
        Green_In = PIX_W'(g);
        Blue_In = PIX_W'(b);
        In_Valid = 1'b1;
        @(posedge Clk);
        #1;
        In_Valid = 1'b0;
        m_r[m_cnt] = r;
        m_g[m_cnt] = g;
        m_b[m_cnt] = b;
        m_cnt++;
        m_sum_valid = 0;
        $display("load pixel %0d: (%0d,%0d,%0d)", m_cnt - 1, r, g, b);
    endtask

    task automatic load_tile_a();
        load_pixel(61, 133, 198);
        load_pixel(61, 133, 198);
        load_pixel(200, 10, 10);
        load_pixel(62, 130, 200);
    endtask

    task automatic pulse_start(input bit s_sum, input bit s_rmv);
        Start_Sum = s_sum;
        Start_BgRemoval = s_rmv;
        @(posedge Clk);
        #1;
        Start_Sum = 1'b0;
        Start_BgRemoval = 1'b0;
    endtask

    task automatic do_ack();
        Ack = 1'b1;
        @(posedge Clk);
        #1;
        Ack = 1'b0;
    endtask

    task automatic run_sum(input bit both);
        int cyc;
        m_sr = 0; m_sg = 0; m_sb = 0;
        for (int i = 0; i < NUM_PIX; i++) begin
            m_sr += m_r[i]; m_sg += m_g[i]; m_sb += m_b[i];
        end
        pulse_start(1'b1, both);
        cyc = 0;
        while (Busy && cyc < 20) begin
            check("sum_no_output", 32'(Out_Valid), 32'd0);
            cyc++;
            @(posedge Clk);
            #1;
        end
        m_sum_valid = 1;
        $display("sum pass: busy %0d cycles, sums (%0d,%0d,%0d)", cyc, Red_Sum, Green_Sum, Blue_Sum);
        check("sum_busy_cycles", 32'(cyc), 32'd4);
        check("sum_done", 32'(Done), 32'd1);
        check("sum_red", 32'(Red_Sum), 32'(m_sr));
        check("sum_green", 32'(Green_Sum), 32'(m_sg));
        check("sum_blue", 32'(Blue_Sum), 32'(m_sb));
        check("sum_valid", 32'(Sum_Valid), 32'd1);
        check("sum_repl_hold", 32'(Replaced_Count), 32'(exp_replaced));
        @(posedge Clk);
        #1;
        check("sum_done_hold", 32'(Done), 32'd1);
        do_ack();
        check("sum_ack_done", 32'(Done), 32'd0);
        check("sum_ack_full", 32'(Buffer_Full), 32'd1);
        check("sum_ack_valid", 32'(Sum_Valid), 32'd1);
    endtask

    task automatic set_rmv_inputs(input bit use_avg, input int er, input int eg, input int eb,
                                  input int thr, input int br, input int bgc, input int bb);
        int ex, ey, ez, d;
        Use_Avg = use_avg;
        Red_Exp = PIX_W'(er); Green_Exp = PIX_W'(eg); Blue_Exp = PIX_W'(eb);
        Threshold = DIST_W'(thr);
        Bg_Red = PIX_W'(br); Bg_Green = PIX_W'(bgc); Bg_Blue = PIX_W'(bb);
        if (use_avg && m_sum_valid) begin
            ex = m_sr / NUM_PIX; ey = m_sg / NUM_PIX; ez = m_sb / NUM_PIX;
        end else begin
            ex = er; ey = eg; ez = eb;
        end
        exp_replaced = 0;
        sb_q.delete();
        hs_cnt = 0;
        for (int i = 0; i < NUM_PIX; i++) begin
            d = ((m_r[i] > ex) ? m_r[i] - ex : ex - m_r[i])
              + ((m_g[i] > ey) ? m_g[i] - ey : ey - m_g[i])
              + ((m_b[i] > ez) ? m_b[i] - ez : ez - m_b[i]);
            if (d <= thr) begin
                sb_q.push_back({8'(br), 8'(bgc), 8'(bb)});
                exp_replaced++;
            end else begin
                sb_q.push_back({8'(m_r[i]), 8'(m_g[i]), 8'(m_b[i])});
            end
        end
    endtask

    task automatic run_rmv(input bit use_avg, input int er, input int eg, input int eb,
                           input int thr, input int br, input int bgc, input int bb, input bit toggle);
        int cyc;
        set_rmv_inputs(use_avg, er, eg, eb, thr, br, bgc, bb);
        Out_Ready = toggle ? 1'b0 : 1'b1;
        pulse_start(1'b0, 1'b1);
        check("rmv_first_ov0", 32'(Out_Valid), 32'd0);
        check("rmv_busy", 32'(Busy), 32'd1);
        cyc = 0;
        while (!Done && cyc < 100) begin
            if (toggle) Out_Ready = ~Out_Ready;
            @(posedge Clk);
            #1;
            cyc++;
            if (cyc == 1 && !toggle) check("rmv_first_ov1", 32'(Out_Valid), 32'd1);
        end
        $display("rmv pass: %0d cycles, %0d handshakes, replaced %0d", cyc, hs_cnt, Replaced_Count);
        check("rmv_done", 32'(Done), 32'd1);
        if (!toggle) check("rmv_cycles", 32'(cyc), 32'd5);
        check("rmv_handshakes", 32'(hs_cnt), 32'd4);
        check("rmv_sb_left", 32'(sb_q.size()), 32'd0);
        check("rmv_replaced", 32'(Replaced_Count), 32'(exp_replaced));
        check("rmv_ov_end", 32'(Out_Valid), 32'd0);
        Out_Ready = 1'b1;
        do_ack();
        m_cnt = 0;
        m_sum_valid = 0;
        check("rmv_ack_done", 32'(Done), 32'd0);
        check("rmv_ack_full", 32'(Buffer_Full), 32'd0);
        check("rmv_ack_inready", 32'(In_Ready), 32'd1);
        check("rmv_ack_sumvalid", 32'(Sum_Valid), 32'd0);
        check("rmv_repl_hold", 32'(Replaced_Count), 32'(exp_replaced));
    endtask

    initial begin
        int cyc;
        Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_inready", 32'(In_Ready), 32'd1);
        check("rst_outvalid", 32'(Out_Valid), 32'd0);
        check("rst_out", 32'({Red_Out, Green_Out, Blue_Out}), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_sumvalid", 32'(Sum_Valid), 32'd0);
        check("rst_sum", 32'({Red_Sum, Green_Sum, Blue_Sum}), 32'd0);
        check("rst_full", 32'(Buffer_Full), 32'd0);
        check("rst_repl", 32'(Replaced_Count), 32'd0);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // Tile A: sum pass, then fixed-colour removal with back-to-back output.
        load_tile_a();
        check("load_full", 32'(Buffer_Full), 32'd1);
        check("load_inready", 32'(In_Ready), 32'd0);
        run_sum(1'b0);
        run_rmv(1'b0, 61, 133, 198, 10, 0, 255, 0, 1'b0);

        // Tile A again: tile-average expected colour with a stalling sink.
        load_tile_a();
        run_sum(1'b0);
        run_rmv(1'b1, 0, 0, 0, 200, 0, 255, 0, 1'b1);

        // Starts with a partial tile are ignored; simultaneous starts run the sum only.
        load_pixel(10, 20, 30);
        load_pixel(40, 50, 60);
        load_pixel(70, 80, 90);
        pulse_start(1'b0, 1'b1);
        check("partial_rmv_busy", 32'(Busy), 32'd0);
        check("partial_rmv_inready", 32'(In_Ready), 32'd1);
        pulse_start(1'b1, 1'b0);
        check("partial_sum_busy", 32'(Busy), 32'd0);
        check("partial_sum_done", 32'(Done), 32'd0);
        load_pixel(255, 255, 255);
        run_sum(1'b1);

        // Reset in the middle of a removal pass after two outputs.
        set_rmv_inputs(1'b0, 10, 20, 30, 0, 1, 2, 3);
        Out_Ready = 1'b1;
        pulse_start(1'b0, 1'b1);
        cyc = 0;
        while (hs_cnt < 2 && cyc < 50) begin
            @(posedge Clk);
            #1;
            cyc++;
        end
        check("abort_handshakes", 32'(hs_cnt), 32'd2);
        check("abort_pre_valid", 32'(Out_Valid), 32'd1);
        Reset_n = 1'b0;
        #1;
        check("abort_outvalid", 32'(Out_Valid), 32'd0);
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_full", 32'(Buffer_Full), 32'd0);
        check("abort_sumvalid", 32'(Sum_Valid), 32'd0);
        check("abort_repl", 32'(Replaced_Count), 32'd0);
        check("abort_out", 32'({Red_Out, Green_Out, Blue_Out}), 32'd0);
        sb_q.delete();
        m_cnt = 0;
        m_sum_valid = 0;
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        check("abort_inready", 32'(In_Ready), 32'd1);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_sum", 32'(Red_Sum), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
